// File: rtl/ysyx_22050019_hazard_ctrl.sv
// Hazard controller for the 5-stage core: arbitrates memory stall, load-use
// interlock and ID-resolved jumps into stall/bubble/flush controls.
module ysyx_22050019_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int FL_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_busy_i,
  input  logic             if_commite_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_en_i,
  input  logic             id_rs2_en_i,
  input  logic             id_jump_i,
  input  logic             ex_valid_i,
  input  logic             ex_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_busy_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_stall_o,
  output logic             id_ex_bubble_o,
  output logic             id_j_flush_o,
  output logic             if_discard_o,
  output logic             state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [FL_W-1:0]  flush_cnt_o
);

  typedef enum logic {RUN = 1'b0, J_WAIT = 1'b1} state_t;

  state_t state;
  logic   rs1_hit, rs2_hit, lu, jmp;
  logic   jmp_take, jmp_wait;

  assign rs1_hit = id_rs1_en_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_en_i & (id_rs2_i == ex_rd_i);
  assign lu  = ex_valid_i & ex_load_i & (ex_rd_i != 5'd0) & id_valid_i & (rs1_hit | rs2_hit);
  assign jmp = id_valid_i & id_jump_i;

  // A jump is accepted only in RUN with no higher-priority hazard.
  assign jmp_take = ~rst_n & (state == RUN) & ~mem_busy_i & ~lu & jmp;
  // The wrong-path fetch is still outstanding and must be dropped when it lands.
  assign jmp_wait = jmp_take & if_busy_i & ~if_commite_i;

  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    id_ex_bubble_o = 1'b0;
    id_j_flush_o   = 1'b0;
    if_discard_o   = 1'b0;
    if (!rst_n) begin
      if (state == J_WAIT) begin
        // PC already redirected; flush wins over the IF/ID hold.
        id_j_flush_o   = 1'b1;
        if_discard_o   = 1'b1;
        id_ex_stall_o  = mem_busy_i;
        ex_mem_stall_o = mem_busy_i;
      end else if (mem_busy_i) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
      end else if (lu) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (jmp) begin
        id_j_flush_o   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= RUN;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      case (state)
        RUN:     if (jmp_wait) state <= J_WAIT;
        J_WAIT:  if (if_commite_i) state <= RUN;
        default: state <= RUN;
      endcase
      if (pc_stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (jmp_take && flush_cnt_o != '1)   flush_cnt_o <= flush_cnt_o + FL_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_ysyx_22050019_hazard_ctrl.sv
// Directed bench for the hazard controller; a narrow-counter copy exercises saturation.
module tb_ysyx_22050019_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, if_busy, if_commite, id_valid, id_rs1_en, id_rs2_en, id_jump;
  logic ex_valid, ex_load, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic pc_st, ifid_st, idex_st, exmem_st, bub, fl, disc, st;
  logic [31:0] scnt;
  logic [15:0] fcnt;
  logic s_pc_st, s_ifid_st, s_idex_st, s_exmem_st, s_bub, s_fl, s_disc, s_st;
  logic [3:0] s_scnt;
  logic [1:0] s_fcnt;

  int errs = 0, checks = 0;

  ysyx_22050019_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_busy_i(if_busy), .if_commite_i(if_commite),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_en_i(id_rs1_en), .id_rs2_en_i(id_rs2_en), .id_jump_i(id_jump),
    .ex_valid_i(ex_valid), .ex_load_i(ex_load), .ex_rd_i(ex_rd), .mem_busy_i(mem_busy),
    .pc_stall_o(pc_st), .if_id_stall_o(ifid_st), .id_ex_stall_o(idex_st),
    .ex_mem_stall_o(exmem_st), .id_ex_bubble_o(bub), .id_j_flush_o(fl),
    .if_discard_o(disc), .state_o(st), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  ysyx_22050019_hazard_ctrl #(.CNT_W(4), .FL_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_busy_i(if_busy), .if_commite_i(if_commite),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_en_i(id_rs1_en), .id_rs2_en_i(id_rs2_en), .id_jump_i(id_jump),
    .ex_valid_i(ex_valid), .ex_load_i(ex_load), .ex_rd_i(ex_rd), .mem_busy_i(mem_busy),
    .pc_stall_o(s_pc_st), .if_id_stall_o(s_ifid_st), .id_ex_stall_o(s_idex_st),
    .ex_mem_stall_o(s_exmem_st), .id_ex_bubble_o(s_bub), .id_j_flush_o(s_fl),
    .if_discard_o(s_disc), .state_o(s_st), .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
  );

  // {pc, if_id, id_ex, ex_mem, bubble, flush, discard}
  function automatic logic [6:0] ctl();
    return {pc_st, ifid_st, idex_st, exmem_st, bub, fl, disc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    if_busy = 0; if_commite = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_en = 0; id_rs2_en = 0; id_jump = 0; ex_valid = 0; ex_load = 0;
    ex_rd = 0; mem_busy = 0;
  endtask

  task automatic set_lu();
    id_valid = 1; ex_valid = 1; ex_load = 1; ex_rd = 5; id_rs2 = 5; id_rs2_en = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1; mem_busy = 1; id_valid = 1; id_jump = 1;
    repeat (3) tick();
    chk("rst_ctl", 32'(ctl()), 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_scnt", scnt, 32'd0);
    chk("rst_fcnt", 32'(fcnt), 32'd0);

    rst_n = 0; idle(); #1;
    chk("idle_ctl", 32'(ctl()), 32'd0);

    // load-use via rs2
    set_lu(); #1;
    chk("lu_ctl", 32'(ctl()), 32'(7'b1100100));
    tick(); idle(); #1;
    chk("lu_scnt", scnt, 32'd1);
    set_lu(); ex_rd = 0; id_rs2 = 0; #1;
    chk("lu_rd0", 32'(ctl()), 32'd0);
    set_lu(); id_rs2_en = 0; id_rs1 = 5; id_rs1_en = 0; #1;
    chk("lu_noen", 32'(ctl()), 32'd0);
    idle(); tick();

    // jump, no fetch in flight
    id_valid = 1; id_jump = 1; #1;
    chk("jmp_ctl", 32'(ctl()), 32'(7'b0000010));
    tick(); idle(); #1;
    chk("jmp_state", 32'(st), 32'd0);
    chk("jmp_fcnt", 32'(fcnt), 32'd1);
    chk("jmp_ctl_after", 32'(ctl()), 32'd0);

    // jump with fetch in flight, commit arrives at t+3
    id_valid = 1; id_jump = 1; if_busy = 1; #1;
    chk("jw_t0", 32'(ctl()), 32'(7'b0000010));
    tick(); id_jump = 0; #1;
    chk("jw_t1_state", 32'(st), 32'd1);
    chk("jw_t1_ctl", 32'(ctl()), 32'(7'b0000011));
    set_lu(); id_jump = 1; #1;
    chk("jw_t1_ign", 32'(ctl()), 32'(7'b0000011));
    idle(); if_busy = 1; tick();
    mem_busy = 1; #1;
    chk("jw_t2_mem", 32'(ctl()), 32'(7'b0011011));
    tick(); mem_busy = 0; if_commite = 1; #1;
    chk("jw_t3_state", 32'(st), 32'd1);
    chk("jw_t3_ctl", 32'(ctl()), 32'(7'b0000011));
    tick(); idle(); #1;
    chk("jw_t4_state", 32'(st), 32'd0);
    chk("jw_fcnt", 32'(fcnt), 32'd2);
    chk("jw_scnt", scnt, 32'd1);

    // jump with commit in the same cycle stays in RUN
    id_valid = 1; id_jump = 1; if_busy = 1; if_commite = 1; tick(); idle(); #1;
    chk("jc_state", 32'(st), 32'd0);
    chk("jc_fcnt", 32'(fcnt), 32'd3);

    // priority mem > lu > jmp
    set_lu(); id_jump = 1; mem_busy = 1; #1;
    chk("pri_mem", 32'(ctl()), 32'(7'b1111000));
    tick(); mem_busy = 0; #1;
    chk("pri_mem_cnt", scnt, 32'd2);
    chk("pri_mem_fcnt", 32'(fcnt), 32'd3);
    chk("pri_lu", 32'(ctl()), 32'(7'b1100100));
    tick(); ex_load = 0; #1;
    chk("pri_lu_cnt", scnt, 32'd3);
    chk("pri_lu_fcnt", 32'(fcnt), 32'd3);
    chk("pri_jmp", 32'(ctl()), 32'(7'b0000010));
    tick(); idle(); #1;
    chk("pri_jmp_fcnt", 32'(fcnt), 32'd4);

    // reset while in J_WAIT
    id_valid = 1; id_jump = 1; if_busy = 1; tick(); idle(); #1;
    chk("rj_state", 32'(st), 32'd1);
    rst_n = 1; #1;
    chk("rj_ctl", 32'(ctl()), 32'd0);
    tick(); rst_n = 0; #1;
    chk("rj_state2", 32'(st), 32'd0);
    chk("rj_disc", 32'(disc), 32'd0);
    chk("rj_scnt", scnt, 32'd0);

    // saturation on the narrow copy
    mem_busy = 1; repeat (20) tick(); mem_busy = 0; #1;
    chk("sat_scnt_small", 32'(s_scnt), 32'hF);
    chk("sat_scnt_big", scnt, 32'd20);
    id_valid = 1; id_jump = 1; repeat (5) tick(); idle(); #1;
    chk("sat_fcnt_small", 32'(s_fcnt), 32'h3);
    chk("sat_fcnt_big", 32'(fcnt), 32'd5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
